// File: rtl/subpel_conv3x3.sv
// rtl/subpel_conv3x3.sv - 3x3 zero-padded convolution with pixel-shuffle write-back, one MAC per clock
module subpel_conv3x3 #(
    parameter int IN_CHANNELS  = 1,
    parameter int OUT_CHANNELS = 1,
    parameter int IN_HEIGHT    = 2,
    parameter int IN_WIDTH     = 2,
    parameter int R            = 2,
    parameter int DATA_WIDTH   = 16
) (
    input  logic                                                         clk,
    input  logic                                                         rst,
    input  logic                                                         start,
    input  logic [IN_CHANNELS*IN_HEIGHT*IN_WIDTH*DATA_WIDTH-1:0]         input_tensor_flat,
    input  logic [OUT_CHANNELS*R*R*IN_CHANNELS*9*DATA_WIDTH-1:0]         conv_weights_flat,
    input  logic [OUT_CHANNELS*R*R*DATA_WIDTH-1:0]                       conv_bias_flat,
    output logic                                                         done,
    output logic [OUT_CHANNELS*IN_HEIGHT*R*IN_WIDTH*R*DATA_WIDTH-1:0]    output_tensor_flat
);
    localparam int DW  = DATA_WIDTH;
    localparam int COC = OUT_CHANNELS * R * R;
    localparam int OH  = IN_HEIGHT * R;
    localparam int OW  = IN_WIDTH * R;
    localparam int AW  = 2 * DW + 8;
    localparam int OBW = OUT_CHANNELS * OH * OW * DW;
    localparam int OCW = $clog2(COC + 1);
    localparam int HW  = $clog2(IN_HEIGHT + 1);
    localparam int WW  = $clog2(IN_WIDTH + 1);
    localparam int ICW = $clog2(IN_CHANNELS + 1);

    localparam logic [OCW-1:0] OC_LAST = OCW'(COC - 1);
    localparam logic [HW-1:0]  H_LAST  = HW'(IN_HEIGHT - 1);
    localparam logic [WW-1:0]  W_LAST  = WW'(IN_WIDTH - 1);
    localparam logic [ICW-1:0] IC_LAST = ICW'(IN_CHANNELS - 1);
    localparam logic signed [AW-1:0] SAT_MAX = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [AW-1:0] SAT_MIN = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;
    typedef enum logic [1:0] {PH_BIAS, PH_MAC, PH_WRITE} phase_t;

    state_t                 state_q, state_d;
    phase_t                 phase_q, phase_d;
    logic [OCW-1:0]         oc_q, oc_d;
    logic [HW-1:0]          h_q, h_d;
    logic [WW-1:0]          w_q, w_d;
    logic [ICW-1:0]         ic_q, ic_d;
    logic [1:0]             kh_q, kh_d, kw_q, kw_d;
    logic signed [AW-1:0]   acc_q, acc_d;
    logic                   done_q, done_d;
    logic [OBW-1:0]         out_q, out_d;

    logic signed [DW-1:0]   tap, wt, bias;
    logic signed [2*DW-1:0] prod;
    logic [DW-1:0]          sat_val;
    logic                   in_range, clr;
    int                     ih, iw, in_idx, w_idx, c, i, j, out_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            phase_q <= PH_BIAS;
            oc_q    <= '0;
            h_q     <= '0;
            w_q     <= '0;
            ic_q    <= '0;
            kh_q    <= '0;
            kw_q    <= '0;
            acc_q   <= '0;
            done_q  <= 1'b0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            oc_q    <= oc_d;
            h_q     <= h_d;
            w_q     <= w_d;
            ic_q    <= ic_d;
            kh_q    <= kh_d;
            kw_q    <= kw_d;
            acc_q   <= acc_d;
            done_q  <= done_d;
            out_q   <= out_d;
        end
    end

    // Tap fetch: padded positions read as zero but still consume their cycle.
    always_comb begin
        ih       = int'(h_q) + int'(kh_q) - 1;
        iw       = int'(w_q) + int'(kw_q) - 1;
        in_range = (ih >= 0) && (ih < IN_HEIGHT) && (iw >= 0) && (iw < IN_WIDTH);
        in_idx   = in_range ? (int'(ic_q) * IN_HEIGHT + ih) * IN_WIDTH + iw : 0;
        tap      = in_range ? input_tensor_flat[in_idx*DW +: DW] : '0;
        w_idx    = ((int'(oc_q) * IN_CHANNELS + int'(ic_q)) * 3 + int'(kh_q)) * 3 + int'(kw_q);
        wt       = conv_weights_flat[w_idx*DW +: DW];
        bias     = conv_bias_flat[int'(oc_q)*DW +: DW];
        prod     = tap * wt;
        if (acc_q > SAT_MAX)      sat_val = SAT_MAX[DW-1:0];
        else if (acc_q < SAT_MIN) sat_val = SAT_MIN[DW-1:0];
        else                      sat_val = acc_q[DW-1:0];
        c        = int'(oc_q) / (R * R);
        i        = (int'(oc_q) % (R * R)) / R;
        j        = int'(oc_q) % R;
        out_idx  = (c * OH + int'(h_q) * R + i) * OW + int'(w_q) * R + j;
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        oc_d    = oc_q;
        h_d     = h_q;
        w_d     = w_q;
        ic_d    = ic_q;
        kh_d    = kh_q;
        kw_d    = kw_q;
        acc_d   = acc_q;
        done_d  = done_q;
        out_d   = out_q;
        clr     = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                state_d = COMPUTE;
                clr     = 1'b1;
            end
            COMPUTE: begin
                case (phase_q)
                    PH_BIAS: begin
                        acc_d   = {{(AW-DW){bias[DW-1]}}, bias};
                        phase_d = PH_MAC;
                    end
                    PH_MAC: begin
                        acc_d = acc_q + {{(AW-2*DW){prod[2*DW-1]}}, prod};
                        if (kw_q == 2'd2) begin
                            kw_d = '0;
                            if (kh_q == 2'd2) begin
                                kh_d = '0;
                                if (ic_q == IC_LAST) begin
                                    ic_d    = '0;
                                    phase_d = PH_WRITE;
                                end else begin
                                    ic_d = ic_q + 1'b1;
                                end
                            end else begin
                                kh_d = kh_q + 1'b1;
                            end
                        end else begin
                            kw_d = kw_q + 1'b1;
                        end
                    end
                    PH_WRITE: begin
                        out_d[out_idx*DW +: DW] = sat_val;
                        phase_d = PH_BIAS;
                        if (w_q == W_LAST) begin
                            w_d = '0;
                            if (h_q == H_LAST) begin
                                h_d = '0;
                                if (oc_q == OC_LAST) begin
                                    oc_d    = '0;
                                    state_d = DONE;
                                    done_d  = 1'b1;
                                end else begin
                                    oc_d = oc_q + 1'b1;
                                end
                            end else begin
                                h_d = h_q + 1'b1;
                            end
                        end else begin
                            w_d = w_q + 1'b1;
                        end
                    end
                    default: phase_d = PH_BIAS;
                endcase
            end
            DONE: if (start) begin
                state_d = COMPUTE;
                done_d  = 1'b0;
                clr     = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        if (clr) begin
            phase_d = PH_BIAS;
            oc_d    = '0;
            h_d     = '0;
            w_d     = '0;
            ic_d    = '0;
            kh_d    = '0;
            kw_d    = '0;
            acc_d   = '0;
        end
    end

    assign done               = done_q;
    assign output_tensor_flat = out_q;
endmodule

// File: tb/tb_subpel_conv3x3.sv
// tb/tb_subpel_conv3x3.sv - self-checking bench for subpel_conv3x3 with a behavioural reference model
module tb_subpel_conv3x3;
    localparam int DW    = 16;
    localparam int N_IN  = 4;
    localparam int N_W   = 36;
    localparam int N_B   = 4;
    localparam int N_OUT = 16;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  start;
    logic [N_IN*DW-1:0]    in_flat;
    logic [N_W*DW-1:0]     w_flat;
    logic [N_B*DW-1:0]     b_flat;
    logic                  done;
    logic [N_OUT*DW-1:0]   out_flat;

    int                    in_a[N_IN];
    int                    w_a[N_W];
    int                    b_a[N_B];
    logic [N_OUT*DW-1:0]   exp_flat = '0;
    bit                    exp_valid = 1'b0;
    int                    checks = 0;
    int                    failures = 0;
    int                    lit[N_OUT];

    subpel_conv3x3 dut (
        .clk                (clk),
        .rst                (rst),
        .start              (start),
        .input_tensor_flat  (in_flat),
        .conv_weights_flat  (w_flat),
        .conv_bias_flat     (b_flat),
        .done               (done),
        .output_tensor_flat (out_flat)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s got=%h want=%h", name, act, req);
        end
    endtask

    function automatic logic [N_OUT*DW-1:0] pk(input int v[N_OUT]);
        logic [N_OUT*DW-1:0] r;
        for (int k = 0; k < N_OUT; k++) r[k*DW +: DW] = 16'(v[k]);
        return r;
    endfunction

    function automatic int sat16(input longint v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return int'(v);
    endfunction

    task automatic drive();
        for (int k = 0; k < N_IN; k++) in_flat[k*DW +: DW] = 16'(in_a[k]);
        for (int k = 0; k < N_W; k++)  w_flat[k*DW +: DW]  = 16'(w_a[k]);
        for (int k = 0; k < N_B; k++)  b_flat[k*DW +: DW]  = 16'(b_a[k]);
    endtask

    // Direct convolution followed by pixel shuffle, straight from the definition.
    task automatic model();
        for (int oc = 0; oc < 4; oc++)
            for (int h = 0; h < 2; h++)
                for (int w = 0; w < 2; w++) begin
                    longint acc = longint'(b_a[oc]);
                    for (int kh = 0; kh < 3; kh++)
                        for (int kw = 0; kw < 3; kw++) begin
                            int y = h + kh - 1;
                            int x = w + kw - 1;
                            if (y >= 0 && y < 2 && x >= 0 && x < 2)
                                acc += longint'(in_a[y*2+x]) * longint'(w_a[oc*9+kh*3+kw]);
                        end
                    exp_flat[(((oc/4)*4 + h*2 + (oc%4)/2)*4 + w*2 + oc%2)*DW +: DW] = 16'(sat16(acc));
                end
    endtask

    task automatic clear_params();
        for (int k = 0; k < N_IN; k++) in_a[k] = 0;
        for (int k = 0; k < N_W; k++)  w_a[k] = 0;
        for (int k = 0; k < N_B; k++)  b_a[k] = 0;
    endtask

    task automatic run(input bit mid_start);
        int n;
        drive();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        model();
        exp_valid = 1'b1;
        check("done_drop", 256'(done), 256'(0));
        n = 0;
        while (!done && n < 1000) begin
            @(posedge clk); #1;
            n++;
            if (mid_start && n == 20) start = 1'b1;
            if (n == 21) start = 1'b0;
        end
        check("latency", 256'(n), 256'(176));
    endtask

    always @(negedge clk) begin
        if (!rst && done && exp_valid) check("done_out", 256'(out_flat), 256'(exp_flat));
    end

    initial begin
        rst = 1'b1;
        start = 1'b0;
        clear_params();
        drive();
        repeat (3) @(posedge clk);
        #1;
        check("reset_done", 256'(done), 256'(0));
        check("reset_out", 256'(out_flat), 256'(0));
        rst = 1'b0;
        @(posedge clk); #1;

        w_a[4] = 1; w_a[13] = 2; w_a[22] = 3; w_a[31] = 4;
        in_a = '{1, 2, 3, 4};
        run(1'b0);
        lit = '{1, 2, 2, 4, 3, 4, 6, 8, 3, 6, 4, 8, 9, 12, 12, 16};
        check("s1_model", 256'(exp_flat), 256'(pk(lit)));
        check("s1_dut", 256'(out_flat), 256'(pk(lit)));

        b_a = '{10, 20, 30, 40};
        run(1'b0);
        lit = '{11, 22, 12, 24, 33, 44, 36, 48, 13, 26, 14, 28, 39, 52, 42, 56};
        check("s2_model", 256'(exp_flat), 256'(pk(lit)));
        check("s2_dut", 256'(out_flat), 256'(pk(lit)));

        clear_params();
        in_a = '{1, 2, 3, 4};
        for (int k = 0; k < 9; k++) w_a[k] = 1;
        run(1'b0);
        lit = '{10, 0, 10, 0, 0, 0, 0, 0, 10, 0, 10, 0, 0, 0, 0, 0};
        check("s3_model", 256'(exp_flat), 256'(pk(lit)));
        check("s3_dut", 256'(out_flat), 256'(pk(lit)));

        clear_params();
        in_a = '{32767, 32767, 32767, 32767};
        w_a[4] = 2;
        run(1'b0);
        check("s4_pos_sat", 256'(out_flat[15:0]), 256'(16'h7fff));
        in_a = '{-1, -1, -1, -1};
        w_a[4] = 3;
        run(1'b0);
        check("s4_neg", 256'(out_flat[15:0]), 256'(16'hfffd));
        in_a = '{-32768, -32768, -32768, -32768};
        w_a[4] = 2;
        run(1'b0);
        check("s4_neg_sat", 256'(out_flat[15:0]), 256'(16'h8000));
        check("s4_model", 256'(exp_flat[15:0]), 256'(16'h8000));

        clear_params();
        in_a = '{1, 2, 3, 4};
        w_a[4] = 1; w_a[13] = 2; w_a[22] = 3; w_a[31] = 4;
        drive();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_done", 256'(done), 256'(0));
        check("midrst_out", 256'(out_flat), 256'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run(1'b0);
        lit = '{1, 2, 2, 4, 3, 4, 6, 8, 3, 6, 4, 8, 9, 12, 12, 16};
        check("s5_dut", 256'(out_flat), 256'(pk(lit)));

        for (int k = 0; k < N_W; k++) w_a[k] = int'($urandom_range(0, 15)) - 8;
        run(1'b1);
        check("s6_restart", 256'(out_flat), 256'(exp_flat));

        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < N_IN; k++)
                in_a[k] = (r < 3) ? int'($urandom_range(0, 63)) - 32 : int'($urandom_range(0, 65535)) - 32768;
            for (int k = 0; k < N_W; k++)
                w_a[k] = (r < 3) ? int'($urandom_range(0, 63)) - 32 : int'($urandom_range(0, 65535)) - 32768;
            for (int k = 0; k < N_B; k++)
                b_a[k] = int'($urandom_range(0, 65535)) - 32768;
            run(r[0]);
            check("rand", 256'(out_flat), 256'(exp_flat));
        end

        repeat (3) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/subpel_conv3x3.md
Name: subpel_conv3x3

Overview:
Sub-pixel upsampling convolution. A 3x3, stride-1, zero-padded (pad=1) 2D convolution produces OUT_CHANNELS*R*R channels at input resolution. A pixel shuffle then rearranges those channels into OUT_CHANNELS channels at R-times the height and width. Used as the upsampling stage in decoder/synthesis paths. The block is sequential, runs one multiply-accumulate (MAC) per clock, and all tensors are passed as flat buses.

Parameters:
- IN_CHANNELS, default 1: input channel count (IC).
- OUT_CHANNELS, default 1: channel count after the pixel shuffle (OC).
- IN_HEIGHT, default 2: input height (IH).
- IN_WIDTH, default 2: input width (IW).
- R, default 2: upscale factor.
- DATA_WIDTH, default 16: element width (DW), signed two's complement.
- Derived:
  - CONV_OUT_CHANNELS = OC*R*R
  - OUT_HEIGHT = IH*R
  - OUT_WIDTH = IW*R

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request to begin a computation.
- input_tensor_flat  in  IC*IH*IW*DW  input element [c][h][w] at index (c*IH+h)*IW+w.
- conv_weights_flat  in  CONV_OUT_CHANNELS*IC*9*DW  weight [oc][ic][kh][kw] at index ((oc*IC+ic)*3+kh)*3+kw.
- conv_bias_flat  in  CONV_OUT_CHANNELS*DW  bias [oc] at index oc.
- done  out  1  level signal: result valid.
- output_tensor_flat  out  OC*OUT_HEIGHT*OUT_WIDTH*DW  output element [c][y][x] at index (c*OUT_HEIGHT+y)*OUT_WIDTH+x, registered.

Element k of any bus occupies bits [k*DW +: DW].

Behaviour:
- Reset (async, active-high):
  - state goes to IDLE, done=0, output_tensor_flat=0, all counters and the accumulator clear.
  - Reset asserted mid-computation aborts the run; no partial result is flagged as done.
- States: IDLE, COMPUTE, DONE.
  - IDLE: start=1 moves to COMPUTE and clears all loop counters.
  - COMPUTE: start is ignored. After the last write, the next state is DONE.
  - DONE: done=1, held until start=1. start=1 clears done and re-enters COMPUTE (restart).
- Loop order in COMPUTE: conv channel oc (outer), then h, then w. For each conv output point, one pixel costs IC*9+2 cycles:
  - 1 cycle: acc = sign-extended bias[oc].
  - IC*9 cycles: one MAC each, iterating ic, kh, kw. Tap input is in[ic][h+kh-1][w+kw-1], or 0 when out of range (padding). Padded taps still take their cycle.
  - 1 cycle: saturate and write.
- Latency: CONV_OUT_CHANNELS*IH*IW*(IC*9+2) clocks in COMPUTE; done rises on the following edge. For the default parameters this is 4*2*2*11 = 176 cycles.
- Arithmetic:
  - Signed DW x DW product (2*DW bits), accumulated in 2*DW+8 bits.
  - No fixed-point scaling.
  - Final value saturates to [-2^(DW-1), 2^(DW-1)-1].
- Pixel shuffle (write address): conv[oc][h][w] is written to out[c][h*R+i][w*R+j], where c = oc/(R*R), i = (oc%(R*R))/R, j = oc%R.
- Input stability: inputs are not latched. They must stay stable from start until done.
- Output update:
  - Each output element is written exactly once per run.
  - Elements not yet rewritten keep their previous values during COMPUTE.
  - Outputs hold after done.

Test Plan:
1. Basic shuffle (default parameters).
   - Stimulus: input [1,2;3,4]; center weights (kh=kw=1) = 1,2,3,4 for oc 0..3, other weights 0; biases 0.
   - Required output rows: 1 2 2 4 / 3 4 6 8 / 3 6 4 8 / 9 12 12 16.
   - done rises 176 cycles after start.
2. Bias.
   - Stimulus: same as scenario 1 with biases 10,20,30,40.
   - Required output rows: 11 22 12 24 / 33 44 36 48 / 13 26 14 28 / 39 52 42 56.
3. Padding/neighbourhood.
   - Stimulus: input [1,2;3,4]; all 9 weights of oc0 = 1; oc1..oc3 weights 0; biases 0.
   - Required: every out[0][2h][2w] = 10; all other outputs 0.
4. Signed values and saturation.
   - Stimulus: input 0x7FFF with oc0 center weight 2 -> 0x7FFF (clamped).
   - Stimulus: input 0xFFFF (-1) with weight 3 -> 0xFFFD.
   - Stimulus: input 0x8000 with weight 2 -> 0x8000.
5. Reset mid-run.
   - Stimulus: assert rst 50 cycles into COMPUTE.
   - Required: done=0 and outputs=0 immediately.
   - Then a fresh start completes with scenario 1 values.
6. Restart from DONE.
   - Stimulus: change weights, then pulse start while done=1.
   - Required: done drops the next cycle; new result and done arrive after 176 cycles.
   - A start pulsed during COMPUTE is ignored and does not alter latency.
